ram1_bus_sequencer: RTL
=======================

Name: ram1_bus_sequencer

Overview:
- Sequences the shared Ram1 bus (SRAM plus the on-board UART) for the CPU MEM stage.
- Decodes each load/store address into one of three targets: SRAM, UART data register, UART status register.
- Generates the SRAM and UART strobes with correct setup and hold timing.
- Stalls the pipeline through busy until the access completes.
- Sits between the MEM stage and the Ram1/UART pins of the top-level cpu.

Parameters:
- UART_DATA_ADDR, 16'hBF00, UART data register address.
- UART_STAT_ADDR, 16'hBF01, UART status register address.
- ADDR_W, 18, Ram1Addr width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- req  in  1  MEM-stage access request; held until done
- we  in  1  1 = store, 0 = load; sampled with req
- addr  in  16  access address
- wdata  in  16  store data
- rdata  out  16  load result; valid while done=1, held until the next load completes
- busy  out  1  stall to pipeline
- done  out  1  one-cycle completion pulse
- Ram1Addr  out  ADDR_W  SRAM address
- Ram1Data  inout  16  shared SRAM/UART data bus
- Ram1OE  out  1  SRAM output enable, active-low
- Ram1WE  out  1  SRAM write enable, active-low
- Ram1EN  out  1  SRAM chip enable, active-low
- data_ready  in  1  UART has a received byte
- tbre  in  1  UART transmit buffer empty
- tsre  in  1  UART transmit shift register empty
- wrn  out  1  UART write strobe, active-low
- rdn  out  1  UART read strobe, active-low

Behaviour:
- All strobes are registered Moore outputs.
- Reset/idle output values:
  - Ram1EN=1, Ram1OE=1, Ram1WE=1, wrn=1, rdn=1.
  - Ram1Addr=0, rdata=0, done=0.
  - Ram1Data high-Z.
- busy = req & (state==IDLE), OR (state not IDLE and not DONE). Combinational, so the pipeline stalls in the same cycle req rises.
- States: IDLE, MEM_RD, MEM_WR1, MEM_WR2, U_WR1, U_WR2, U_WAIT, U_RDW, U_RD, STAT, DONE.
- IDLE: on a clock edge with req=1, latch we/addr/wdata and decode:
  - addr==UART_STAT_ADDR -> STAT.
  - addr==UART_DATA_ADDR -> U_WR1 if we, else U_RDW.
  - otherwise -> MEM_WR1 if we, else MEM_RD.
  - Ram1Addr = {2'b00, addr} for SRAM accesses.
- MEM_RD: EN=0, OE=0, bus Z. Next edge captures Ram1Data into rdata -> DONE.
- MEM_WR1: EN=0, drive wdata, WE=1 (setup) -> MEM_WR2.
- MEM_WR2: WE=0, wdata still driven -> DONE.
- DONE after a store: WE=1, data still driven for one cycle of hold; EN=1.
- UART states: EN=1 (SRAM disabled so the UART owns the bus).
  - U_WR1: drive wdata, wrn=1 -> U_WR2.
  - U_WR2: wrn=0 for exactly 1 cycle -> U_WAIT.
  - U_WAIT: wrn=1, bus Z; stay until tbre=1 and tsre=1 sampled together -> DONE. No timeout.
  - U_RDW: bus Z, rdn=1; stay until data_ready=1 -> U_RD.
  - U_RD: rdn=0 for 1 cycle; at the edge, rdata = {8'h00, Ram1Data[7:0]} -> DONE with rdn=1.
- STAT: no strobes; rdata = {14'b0, data_ready, tbre&tsre} -> DONE.
- DONE: done=1 for 1 cycle, busy=0; req is ignored; -> IDLE.
  - A request still high in the following IDLE cycle is accepted again (back-to-back).
- Latency, req accept edge to done cycle:
  - SRAM read: 2 cycles.
  - SRAM write: 3 cycles.
  - STAT: 2 cycles.
  - UART accesses: variable.
- Ram1Data is driven only in MEM_WR1, MEM_WR2, U_WR1, U_WR2, and DONE following MEM_WR2. Never driven while OE=0 or rdn=0.
- rst=1 at any edge, including mid-access: next cycle is IDLE with all reset values. A pending req is re-evaluated only after rst deasserts.
- Addresses in the upper half of the address space are treated as SRAM; only the two exact UART addresses divert.

Test Plan:
- SRAM store addr=0x0001, wdata=0x00B0, then load 0x0001:
  - Ram1WE low exactly 1 cycle; done 3 cycles after accept.
  - Load done 2 cycles after accept with rdata=0x00B0.
- UART store 0xBF00 with wdata=0x0041, tbre=0 for 5 cycles, then tbre=tsre=1:
  - wrn low exactly 1 cycle with bus=0x0041, Ram1EN=1 throughout.
  - busy high until the cycle after both flags are 1, then a single done pulse.
- Status load 0xBF01 with data_ready=1, tbre=1, tsre=0 -> rdata=0x0002, done 2 cycles after accept, no strobes toggle.
- UART load 0xBF00, data_ready rises after 4 cycles, bus=0x1234 -> rdn low 1 cycle, rdata=0x0034.
- rst pulsed during U_WAIT -> next cycle wrn=rdn=Ram1EN=Ram1OE=Ram1WE=1, bus Z, done=0, busy=req.
- Back-to-back SRAM loads, req held through done -> second access accepted the cycle after DONE; total 6 cycles for two loads; no contention on Ram1Data.

Source files
------------

// File: rtl/ram1_bus_sequencer.sv
// Ram1 bus sequencer: steers MEM-stage loads/stores to the SRAM or the on-board
// UART with registered strobes, stalling the pipeline until each access finishes.
module ram1_bus_sequencer #(
  parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
  parameter logic [15:0] UART_STAT_ADDR = 16'hBF01,
  parameter int          ADDR_W         = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [15:0]       addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] Ram1Addr,
  inout  wire  [15:0]       Ram1Data,
  output logic              Ram1OE,
  output logic              Ram1WE,
  output logic              Ram1EN,
  input  logic              data_ready,
  input  logic              tbre,
  input  logic              tsre,
  output logic              wrn,
  output logic              rdn
);

  typedef enum logic [3:0] {
    IDLE, MEM_RD, MEM_WR1, MEM_WR2, U_WR1, U_WR2, U_WAIT, U_RDW, U_RD, STAT, DONE
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] wdata_q;
  logic        bus_drive;
  logic        en_nxt, oe_nxt, we_nxt, wrn_nxt, rdn_nxt, drive_nxt;
  logic        accept, is_uart;

  assign accept  = (state == IDLE) && req;
  assign is_uart = (addr == UART_DATA_ADDR) || (addr == UART_STAT_ADDR);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (addr == UART_STAT_ADDR)      state_nxt = STAT;
          else if (addr == UART_DATA_ADDR) state_nxt = we ? U_WR1 : U_RDW;
          else                             state_nxt = we ? MEM_WR1 : MEM_RD;
        end
      end
      MEM_RD:  state_nxt = DONE;
      MEM_WR1: state_nxt = MEM_WR2;
      MEM_WR2: state_nxt = DONE;
      U_WR1:   state_nxt = U_WR2;
      U_WR2:   state_nxt = U_WAIT;
      U_WAIT:  if (tbre && tsre) state_nxt = DONE;
      U_RDW:   if (data_ready) state_nxt = U_RD;
      U_RD:    state_nxt = DONE;
      STAT:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are decoded from the next state and registered, so they change only on clk.
  always_comb begin
    en_nxt    = !(state_nxt inside {MEM_RD, MEM_WR1, MEM_WR2});
    oe_nxt    = (state_nxt != MEM_RD);
    we_nxt    = (state_nxt != MEM_WR2);
    wrn_nxt   = (state_nxt != U_WR2);
    rdn_nxt   = (state_nxt != U_RD);
    // Keep store data on the bus one extra cycle after WE rises for SRAM hold time.
    drive_nxt = (state_nxt inside {MEM_WR1, MEM_WR2, U_WR1, U_WR2}) ||
                ((state == MEM_WR2) && (state_nxt == DONE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      Ram1EN    <= 1'b1;
      Ram1OE    <= 1'b1;
      Ram1WE    <= 1'b1;
      wrn       <= 1'b1;
      rdn       <= 1'b1;
      bus_drive <= 1'b0;
      done      <= 1'b0;
      rdata     <= 16'h0000;
      Ram1Addr  <= '0;
    end else begin
      state     <= state_nxt;
      Ram1EN    <= en_nxt;
      Ram1OE    <= oe_nxt;
      Ram1WE    <= we_nxt;
      wrn       <= wrn_nxt;
      rdn       <= rdn_nxt;
      bus_drive <= drive_nxt;
      done      <= (state_nxt == DONE);
      if (accept && !is_uart) Ram1Addr <= ADDR_W'(addr);
      case (state)
        MEM_RD:  rdata <= Ram1Data;
        U_RD:    rdata <= {8'h00, Ram1Data[7:0]};
        STAT:    rdata <= {14'b0, data_ready, tbre & tsre};
        default: rdata <= rdata;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) wdata_q <= wdata;
  end

  assign Ram1Data = bus_drive ? wdata_q : 16'hzzzz;
  assign busy     = (state == IDLE) ? req : (state != DONE);

endmodule
